// File: rtl/seg7_pkg.sv
// seg7_pkg: scan FSM states, hex segment table and output polarity helpers for seg7_scan
package seg7_pkg;

  typedef enum logic {BLANK, DRIVE} state_e;

  // Active-high {g,f,e,d,c,b,a} codes, entry 15 first.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] seg_pol(input logic [7:0] s, input logic act_low);
    return act_low ? ~s : s;
  endfunction

  function automatic logic bit_pol(input logic b, input logic act_low);
    return act_low ? ~b : b;
  endfunction

endpackage

// File: rtl/seg7_scan_decode.sv
// seg7_decode: nibble plus decimal point to active-high {dp,g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_i, SEG_TAB[nib_i]};

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scan driver with blanking and frame-synced double buffer; define SEG7_LZB_EN for leading-zero blanking
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIG     = 8,
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLANK_CYC   = 16,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIG-1:0]   dig_en,
  input  logic [4*NUM_DIG-1:0] value,
  input  logic [NUM_DIG-1:0]   dp,
  input  logic                 value_load,
  output logic [7:0]           seg,
  output logic [NUM_DIG-1:0]   dig_sel,
  output logic                 frame_done
);

  localparam int   DIV = CLK_HZ / SCAN_HZ;
  localparam int   CW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int   IW  = NUM_DIG > 1 ? $clog2(NUM_DIG) : 1;
  localparam int   BW  = BLANK_CYC > 1 ? $clog2(BLANK_CYC) : 1;
  localparam logic SL  = SEG_ACT_LOW != 0;
  localparam logic DL  = DIG_ACT_LOW != 0;

  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [BW-1:0]        blank_q;
  state_e               state_q;
  logic [4*NUM_DIG-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIG-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d, dig_en_q;
  logic [7:0]           seg_q, seg_d, seg_ah;
  logic [NUM_DIG-1:0]   dig_sel_q, dig_sel_d;
  logic                 frame_done_q;
  logic                 tick, wrap, on, shown;

  assign tick = cnt_q == CW'(DIV - 1);
  assign wrap = tick && idx_q == IW'(NUM_DIG - 1);

  // A load on the wrap edge bypasses pending so it reaches the new frame directly.
  always_comb begin
    pend_val_d = value_load ? value : pend_val_q;
    pend_dp_d  = value_load ? dp : pend_dp_q;
    act_val_d  = wrap ? pend_val_d : act_val_q;
    act_dp_d   = wrap ? pend_dp_d : act_dp_q;
  end

`ifdef SEG7_LZB_EN
  logic [IW-1:0] hi;
  // Digits above the highest nonzero nibble stay dark unless their dp is lit.
  always_comb begin
    hi = '0;
    for (int k = 0; k < NUM_DIG; k++)
      if (act_val_q[4*k +: 4] != 4'h0) hi = IW'(k);
    shown = idx_q <= hi || act_dp_q[idx_q];
  end
`else
  assign shown = 1'b1;
`endif

  seg7_decode u_dec (
    .nib_i (act_val_q[{idx_q, 2'b00} +: 4]),
    .dp_i  (act_dp_q[idx_q]),
    .seg_o (seg_ah)
  );

  assign on        = state_q == DRIVE && dig_en_q[idx_q];
  assign seg_d     = seg_pol(on && shown ? seg_ah : 8'h00, SL);
  assign dig_sel_d = {NUM_DIG{DL}} ^ (on ? (NUM_DIG'(1) << idx_q) : {NUM_DIG{1'b0}});

  // Prescaler, input mask register and value buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      dig_en_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
    end else begin
      cnt_q      <= tick ? '0 : cnt_q + CW'(1);
      dig_en_q   <= dig_en;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
    end
  end

  // Scan FSM: each digit slot starts blanked, then drives; outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      state_q      <= BLANK;
      blank_q      <= '0;
      seg_q        <= seg_pol(8'h00, SL);
      dig_sel_q    <= {NUM_DIG{bit_pol(1'b0, DL)}};
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= wrap;
      if (tick) begin
        idx_q   <= wrap ? '0 : idx_q + IW'(1);
        state_q <= BLANK;
        blank_q <= '0;
      end else if (state_q == BLANK) begin
        if (blank_q == BW'(BLANK_CYC - 1)) state_q <= DRIVE;
        else blank_q <= blank_q + BW'(1);
      end
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule
